// File: rtl/core_id_queue.sv
// Decode-to-execute operand queue with writeback forwarding and snooping.
// Optional load-use interlock enabled by CORE_ID_QUEUE_LOADUSE_EN.
module core_id_queue #(
  parameter int XLEN   = 64,
  parameter int DEPTH  = 2,
  parameter int NUM_WB = 2,
  parameter int CTRL_W = 96
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [XLEN-1:0]            flush_pc,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4:0]                 in_rs,
  input  logic [4:0]                 in_rt,
  input  logic                       in_b_is_reg,
  input  logic [4:0]                 in_wreg,
  input  logic                       in_we,
  input  logic                       in_is_load,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [XLEN-1:0]            in_A,
  input  logic [XLEN-1:0]            in_B,
  input  logic [NUM_WB-1:0]          wb_we,
  input  logic [NUM_WB*5-1:0]        wb_regnum,
  input  logic [NUM_WB*XLEN-1:0]     wb_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_A,
  output logic [XLEN-1:0]            out_B,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [XLEN-1:0]            out_pc,
  output logic [4:0]                 out_wreg,
  output logic                       out_we,
  output logic                       out_is_load,
  output logic [XLEN-1:0]            epc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic              bisr;
    logic [4:0]        wreg;
    logic              we;
    logic              ld;
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
  } ent_t;

  ent_t          ent_q [DEPTH];
  ent_t          ent_d [DEPTH];
  ent_t          new_e;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic          enq, deq, stall, nonempty;

  // Lowest-index writeback port matching a nonzero source wins.
  function automatic logic [XLEN-1:0] fwd(
    input logic [4:0]      r,
    input logic            en,
    input logic [XLEN-1:0] dflt
  );
    fwd = dflt;
    for (int p = NUM_WB - 1; p >= 0; p--) begin
      if (en && r != 5'd0 && wb_we[p] &&
          wb_regnum[5*p +: 5] == r)
        fwd = wb_data[XLEN*p +: XLEN];
    end
  endfunction

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    inc = (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign nonempty  = cnt_q != '0;
  assign in_ready  = !reset && !flush && (cnt_q < CW'(DEPTH));
  assign out_valid = !reset && !flush && nonempty && !stall;
  assign enq       = in_valid && in_ready;
  assign deq       = out_valid && out_ready;

  assign out_A       = nonempty ? ent_q[rptr_q].a    : '0;
  assign out_B       = nonempty ? ent_q[rptr_q].b    : '0;
  assign out_ctrl    = nonempty ? ent_q[rptr_q].ctrl : '0;
  assign out_pc      = nonempty ? ent_q[rptr_q].pc   : '0;
  assign out_wreg    = nonempty ? ent_q[rptr_q].wreg : '0;
  assign out_we      = nonempty && ent_q[rptr_q].we;
  assign out_is_load = nonempty && ent_q[rptr_q].ld;
  assign epc         = epc_q;
  assign count       = cnt_q;

  // Build the incoming entry with writeback forwarding applied.
  always_comb begin
    new_e      = '0;
    new_e.rs   = in_rs;
    new_e.rt   = in_rt;
    new_e.bisr = in_b_is_reg;
    new_e.wreg = in_wreg;
    new_e.we   = in_we;
    new_e.ld   = in_is_load;
    new_e.ctrl = in_ctrl;
    new_e.pc   = in_pc;
    new_e.a    = fwd(in_rs, 1'b1, in_A);
    new_e.b    = fwd(in_rt, in_b_is_reg, in_B);
  end

  // Snoop resident entries; the enqueue slot takes the new entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (!flush) begin
        ent_d[i].a = fwd(ent_q[i].rs, 1'b1, ent_q[i].a);
        ent_d[i].b = fwd(ent_q[i].rt, ent_q[i].bisr,
                         ent_q[i].b);
        if (enq && wptr_q == PW'(i))
          ent_d[i] = new_e;
      end
    end
  end

  // Pointer, occupancy and exception-PC next state.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    epc_d  = epc_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      epc_d  = flush_pc;
    end else begin
      if (enq) wptr_d = inc(wptr_q);
      if (deq) begin
        rptr_d = inc(rptr_q);
        epc_d  = ent_q[rptr_q].pc;
      end
      unique case ({enq, deq})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Queue state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      epc_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      epc_q  <= epc_d;
    end
  end

`ifdef CORE_ID_QUEUE_LOADUSE_EN
  logic       lu_q, lu_d;
  logic [4:0] luw_q, luw_d;

  // Remember a just-issued load so the next head can wait one cycle.
  always_comb begin
    lu_d  = 1'b0;
    luw_d = luw_q;
    if (!flush && deq) begin
      lu_d  = ent_q[rptr_q].ld && ent_q[rptr_q].we &&
              ent_q[rptr_q].wreg != 5'd0;
      luw_d = ent_q[rptr_q].wreg;
    end
  end

  assign stall = lu_q &&
    (ent_q[rptr_q].rs == luw_q ||
     (ent_q[rptr_q].bisr && ent_q[rptr_q].rt == luw_q));

  // Load-use interlock registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      lu_q  <= 1'b0;
      luw_q <= '0;
    end else begin
      lu_q  <= lu_d;
      luw_q <= luw_d;
    end
  end
`else
  assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_core_id_queue.sv
// Directed bench for core_id_queue (DEPTH=2, NUM_WB=2).
// Table of per-cycle stimulus/expectations plus a load-use sequence.
module tb_core_id_queue;

  logic         clock = 1'b0;
  logic         reset, flush, in_valid, in_ready;
  logic [63:0]  flush_pc;
  logic [4:0]   in_rs, in_rt, in_wreg;
  logic         in_b_is_reg, in_we, in_is_load;
  logic [95:0]  in_ctrl;
  logic [63:0]  in_pc, in_A, in_B;
  logic [1:0]   wb_we;
  logic [9:0]   wb_regnum;
  logic [127:0] wb_data;
  logic         out_valid, out_ready, out_we, out_is_load;
  logic [63:0]  out_A, out_B, out_pc, epc;
  logic [95:0]  out_ctrl;
  logic [4:0]   out_wreg;
  logic [1:0]   count;

  core_id_queue dut (
    .clock(clock), .reset(reset), .flush(flush),
    .flush_pc(flush_pc), .in_valid(in_valid),
    .in_ready(in_ready), .in_rs(in_rs), .in_rt(in_rt),
    .in_b_is_reg(in_b_is_reg), .in_wreg(in_wreg),
    .in_we(in_we), .in_is_load(in_is_load),
    .in_ctrl(in_ctrl), .in_pc(in_pc), .in_A(in_A),
    .in_B(in_B), .wb_we(wb_we), .wb_regnum(wb_regnum),
    .wb_data(wb_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_A(out_A), .out_B(out_B),
    .out_ctrl(out_ctrl), .out_pc(out_pc),
    .out_wreg(out_wreg), .out_we(out_we),
    .out_is_load(out_is_load), .epc(epc), .count(count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst, fl, iv;
    logic [4:0]  rs, rt;
    logic        bisr;
    logic [4:0]  wreg;
    logic        we, ld;
    logic [63:0] pc, a, b;
    logic        ordy;
    logic [1:0]  wbwe;
    logic [4:0]  r0, r1;
    logic [63:0] d0, d1;
    logic        e_irdy, e_ov;
    logic [1:0]  e_cnt;
    logic [63:0] e_pc, e_a, e_b, e_epc;
  } vec_t;

  vec_t tbl[$];
  vec_t cur;
  int   total = 0;
  int   passed = 0;

  task automatic s(input logic rst, fl, iv,
                   input logic [4:0] rs, rt,
                   input logic bisr,
                   input logic [4:0] wreg,
                   input logic we, ld,
                   input logic [63:0] pc, a, b,
                   input logic ordy);
    cur.rst = rst; cur.fl = fl; cur.iv = iv;
    cur.rs = rs; cur.rt = rt; cur.bisr = bisr;
    cur.wreg = wreg; cur.we = we; cur.ld = ld;
    cur.pc = pc; cur.a = a; cur.b = b;
    cur.ordy = ordy;
  endtask

  task automatic w(input logic [1:0] we,
                   input logic [4:0] r0, r1,
                   input logic [63:0] d0, d1);
    cur.wbwe = we; cur.r0 = r0; cur.r1 = r1;
    cur.d0 = d0; cur.d1 = d1;
  endtask

  task automatic e(input logic irdy, ov,
                   input logic [1:0] cnt,
                   input logic [63:0] pc, a, b, ep);
    cur.e_irdy = irdy; cur.e_ov = ov; cur.e_cnt = cnt;
    cur.e_pc = pc; cur.e_a = a; cur.e_b = b;
    cur.e_epc = ep;
    tbl.push_back(cur);
    w(0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string nm,
                     input logic [127:0] act, exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; flush = v.fl; in_valid = v.iv;
    in_rs = v.rs; in_rt = v.rt; in_b_is_reg = v.bisr;
    in_wreg = v.wreg; in_we = v.we; in_is_load = v.ld;
    in_pc = v.pc; in_A = v.a; in_B = v.b;
    in_ctrl = {32'hC0DE0000, v.pc};
    out_ready = v.ordy;
    wb_we = v.wbwe;
    wb_regnum = {v.r1, v.r0};
    wb_data = {v.d1, v.d0};
  endtask

  initial begin
    flush_pc = 64'h80000180;
    cur = '{default: '0};
    drive(cur);
    reset = 1'b1;
    repeat (2) @(posedge clock);

    // reset state
    s(1,0,0, 0,0,0, 0,0,0, 0,0,0, 0);
    e(0,0,0, 0,0,0,0);
    // fill / drain
    s(0,0,1, 1,2,1, 0,0,0, 'h10,'hA1,'hB1, 0);
    e(1,0,0, 0,0,0,0);
    s(0,0,1, 3,4,1, 0,0,0, 'h14,'hA2,'hB2, 0);
    e(1,1,1, 'h10,'hA1,'hB1,0);
    s(0,0,1, 0,0,0, 0,0,0, 'h18,0,0, 0);
    e(0,1,2, 'h10,'hA1,'hB1,0);
    s(0,0,0, 0,0,0, 0,0,0, 0,0,0, 1);
    e(0,1,2, 'h10,'hA1,'hB1,0);
    s(0,0,0, 0,0,0, 0,0,0, 0,0,0, 1);
    e(1,1,1, 'h14,'hA2,'hB2,'h10);
    // enqueue forwarding, both ports hit r5
    s(0,0,1, 5,6,0, 0,0,0, 'h20,'h55,'h66, 1);
    w(3, 5, 5, 'hAA, 'hBB);
    e(1,0,0, 0,0,0,'h14);
    // simultaneous enq/deq, r0 never forwarded
    s(0,0,1, 0,0,1, 0,0,0, 'h24,'h77,'h88, 1);
    w(1, 0, 0, 'hDEAD, 0);
    e(1,1,1, 'h20,'hAA,'h66,'h14);
    s(0,0,0, 0,0,0, 0,0,0, 0,0,0, 0);
    w(2, 0, 0, 0, 'h99);
    e(1,1,1, 'h24,'h77,'h88,'h20);
    // snoop
    s(0,0,1, 9,7,1, 0,0,0, 'h28,'h90,'h70, 0);
    e(1,1,1, 'h24,'h77,'h88,'h20);
    s(0,0,0, 0,0,0, 0,0,0, 0,0,0, 1);
    w(2, 0, 7, 0, 'h1234);
    e(0,1,2, 'h24,'h77,'h88,'h20);
    s(0,0,1, 1,7,0, 0,0,0, 'h2C,'h11,'h22, 0);
    e(1,1,1, 'h28,'h90,'h1234,'h24);
    s(0,0,0, 0,0,0, 0,0,0, 0,0,0, 1);
    w(3, 7, 1, 'h5555, 'h4444);
    e(0,1,2, 'h28,'h90,'h1234,'h24);
    // load-use
    s(0,0,1, 2,0,0, 3,1,1, 'h30,'h33,'h34, 1);
    e(1,1,1, 'h2C,'h4444,'h22,'h28);
    s(0,0,1, 3,0,0, 0,0,0, 'h34,'h35,'h36, 1);
    e(1,1,1, 'h30,'h33,'h34,'h2C);
    s(0,0,0, 0,0,0, 0,0,0, 0,0,0, 1);
`ifdef CORE_ID_QUEUE_LOADUSE_EN
    e(1,0,1, 'h34,'h35,'h36,'h30);
    s(0,0,0, 0,0,0, 0,0,0, 0,0,0, 1);
    e(1,1,1, 'h34,'h35,'h36,'h30);
`else
    e(1,1,1, 'h34,'h35,'h36,'h30);
    s(0,0,0, 0,0,0, 0,0,0, 0,0,0, 1);
    e(1,0,0, 0,0,0,'h34);
`endif
    // flush
    s(0,0,1, 0,0,0, 0,0,0, 'h40,'h41,'h42, 0);
    e(1,0,0, 0,0,0,'h34);
    s(0,0,1, 0,0,0, 0,0,0, 'h44,'h45,'h46, 0);
    e(1,1,1, 'h40,'h41,'h42,'h34);
    s(0,1,1, 0,0,0, 0,0,0, 'h48,'h49,'h4A, 1);
    e(0,0,2, 'h40,'h41,'h42,'h34);
    s(0,0,0, 0,0,0, 0,0,0, 0,0,0, 1);
    e(1,0,0, 0,0,0,'h80000180);
    // reset mid-operation
    s(0,0,1, 1,0,0, 0,0,0, 'h50,'h51,'h52, 0);
    e(1,0,0, 0,0,0,'h80000180);
    s(1,0,0, 0,0,0, 0,0,0, 0,0,0, 0);
    w(1, 1, 0, 'hDEAD, 0);
    e(0,0,1, 'h50,'h51,'h52,'h80000180);
    s(0,0,0, 0,0,0, 0,0,0, 0,0,0, 0);
    e(1,0,0, 0,0,0,0);

    foreach (tbl[i]) begin
      @(negedge clock);
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d in_ready", i), 128'(in_ready),
          128'(tbl[i].e_irdy));
      chk($sformatf("v%0d out_valid", i), 128'(out_valid),
          128'(tbl[i].e_ov));
      chk($sformatf("v%0d count", i), 128'(count),
          128'(tbl[i].e_cnt));
      chk($sformatf("v%0d out_pc", i), 128'(out_pc),
          128'(tbl[i].e_pc));
      chk($sformatf("v%0d out_A", i), 128'(out_A),
          128'(tbl[i].e_a));
      chk($sformatf("v%0d out_B", i), 128'(out_B),
          128'(tbl[i].e_b));
      chk($sformatf("v%0d epc", i), 128'(epc),
          128'(tbl[i].e_epc));
    end

    // load to r9, then head uses r9 through the B operand
    cur = '{default: '0};
    @(negedge clock);
    cur.iv = 1; cur.pc = 'h60; cur.wreg = 9;
    cur.we = 1; cur.ld = 1;
    drive(cur);
    @(negedge clock);
    cur = '{default: '0};
    cur.iv = 1; cur.pc = 'h64; cur.rs = 1;
    cur.rt = 9; cur.bisr = 1;
    drive(cur);
    #1;
    chk("h out_wreg", 128'(out_wreg), 128'(9));
    chk("h out_we", 128'(out_we), 128'(1));
    chk("h out_is_load", 128'(out_is_load), 128'(1));
    chk("h out_ctrl", 128'(out_ctrl),
        128'({32'hC0DE0000, 64'h60}));
    @(negedge clock);
    cur = '{default: '0};
    cur.ordy = 1;
    drive(cur);
    #1;
    chk("h issue load", 128'(out_valid), 128'(1));
    chk("h load pc", 128'(out_pc), 128'('h60));
    @(negedge clock);
    #1;
    chk("h use pc", 128'(out_pc), 128'('h64));
`ifdef CORE_ID_QUEUE_LOADUSE_EN
    chk("h bubble", 128'(out_valid), 128'(0));
`else
    chk("h no bubble", 128'(out_valid), 128'(1));
`endif
    @(negedge clock);
    #1;
`ifdef CORE_ID_QUEUE_LOADUSE_EN
    chk("h after bubble", 128'(out_valid), 128'(1));
    chk("h after cnt", 128'(count), 128'(1));
`else
    chk("h after valid", 128'(out_valid), 128'(0));
    chk("h after cnt", 128'(count), 128'(0));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
